// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer: FSM encoding, ALU Select
// codes and Status bit positions.
package alu_seq_pkg;

    localparam int NREGS_DEF = 8;
    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [3:0] SEL_XOR  = 4'd0;
    localparam logic [3:0] SEL_AND  = 4'd1;
    localparam logic [3:0] SEL_OR   = 4'd2;
    localparam logic [3:0] SEL_NOR  = 4'd3;
    localparam logic [3:0] SEL_ADD  = 4'd4;
    localparam logic [3:0] SEL_SUB  = 4'd12;
    localparam logic [3:0] SEL_SHA  = 4'd5;
    localparam logic [3:0] SEL_SHB  = 4'd6;
    localparam logic [3:0] SEL_ZERO = 4'd7;

    localparam int STATUS_C = 3;
    localparam int STATUS_N = 2;
    localparam int STATUS_V = 1;
    localparam int STATUS_Z = 0;

endpackage

// File: rtl/alu_seq_regfile.sv
// NREGS x WIDTH register file: two combinational operand reads, one debug
// read, one synchronous write, asynchronously cleared.
module alu_seq_regfile
    import alu_seq_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int WIDTH = WIDTH_DEF,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr1,
    output logic [WIDTH-1:0] rdata1,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] rdata2,
    input  logic [AW-1:0]    raddr3,
    output logic [WIDTH-1:0] rdata3
);

    logic [NREGS-1:0][WIDTH-1:0] mem_q, mem_d;

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // NOTE: the array is cleared by reset because software may read any
    // register through the debug port before ever writing it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata1 = mem_q[raddr1];
    assign rdata2 = mem_q[raddr2];
    assign rdata3 = mem_q[raddr3];

endmodule

// File: rtl/alu_sequencer.sv
// Initiator-side controller for a combinational ALU: accepts one command,
// drives registered operands, captures the result, writes back and responds.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int WIDTH = WIDTH_DEF,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_sel,
    input  logic             cmd_cin,
    input  logic [AW-1:0]    cmd_rd,
    input  logic [AW-1:0]    cmd_rs1,
    input  logic [AW-1:0]    cmd_rs2,
    input  logic             cmd_imm_en,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_sel,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [3:0]       alu_status,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [3:0]       rsp_status,
    output logic [3:0]       status_q,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    state_e           state_q, state_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [3:0]       alu_sel_q, alu_sel_d;
    logic             alu_cin_q, alu_cin_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [3:0]       rsp_status_q, rsp_status_d;
    logic [3:0]       status_d;
    logic [WIDTH-1:0] rs1_data, rs2_data;
    logic             wb_en;

    alu_seq_regfile #(
        .NREGS (NREGS),
        .WIDTH (WIDTH)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (wb_en),
        .waddr  (rd_q),
        .wdata  (alu_out),
        .raddr1 (cmd_rs1),
        .rdata1 (rs1_data),
        .raddr2 (cmd_rs2),
        .rdata2 (rs2_data),
        .raddr3 (dbg_addr),
        .rdata3 (dbg_data)
    );

    // Writeback happens on the edge that leaves EXEC, alongside the capture.
    assign wb_en = (state_q == EXEC);

    // NOTE: every next-state value defaults to its current value first, so
    // no path through the case leaves a signal unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        cmd_ready_d  = cmd_ready_q;
        rsp_valid_d  = rsp_valid_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        alu_cin_d    = alu_cin_q;
        rd_d         = rd_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        status_d     = status_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    alu_a_d     = rs1_data;
                    alu_b_d     = cmd_imm_en ? cmd_imm : rs2_data;
                    alu_sel_d   = cmd_sel;
                    alu_cin_d   = cmd_cin;
                    rd_d        = cmd_rd;
                    cmd_ready_d = 1'b0;
                    state_d     = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d   = alu_out;
                rsp_status_d = alu_status;
                status_d     = alu_status;
                rsp_valid_d  = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                cmd_ready_d = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cmd_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            alu_cin_q    <= 1'b0;
            rd_q         <= '0;
            rsp_data_q   <= '0;
            rsp_status_q <= '0;
            status_q     <= '0;
        end else begin
            state_q      <= state_d;
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            alu_cin_q    <= alu_cin_d;
            rd_q         <= rd_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
            status_q     <= status_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign alu_cin    = alu_cin_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_status = rsp_status_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a behavioural ALU stands in for the
// parent's ALU, and a transaction-level register model predicts every output.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_sel = '0;
    logic        cmd_cin = 1'b0;
    logic [2:0]  cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
    logic        cmd_imm_en = 1'b0;
    logic [31:0] cmd_imm = '0;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_sel, alu_status;
    logic        alu_cin;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_status, status_q;
    logic [2:0]  dbg_addr = '0;
    logic [31:0] dbg_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [8];
    logic [3:0]  m_status;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_sel    (cmd_sel),
        .cmd_cin    (cmd_cin),
        .cmd_rd     (cmd_rd),
        .cmd_rs1    (cmd_rs1),
        .cmd_rs2    (cmd_rs2),
        .cmd_imm_en (cmd_imm_en),
        .cmd_imm    (cmd_imm),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_cin    (alu_cin),
        .alu_out    (alu_out),
        .alu_status (alu_status),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_status (rsp_status),
        .status_q   (status_q),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    // Reference ALU: returns {C, N, V, Z, result}.
    function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] sel, input logic cin);
        logic [32:0] s;
        logic [31:0] r;
        logic        c, v;
        c = 1'b0;
        v = 1'b0;
        s = '0;
        case (sel[2:0])
            3'd0: r = a ^ b;
            3'd1: r = a & b;
            3'd2: r = a | b;
            3'd3: r = ~(a | b);
            3'd4: begin
                if (sel[3]) begin
                    s = {1'b0, a} + {1'b0, ~b} + {32'd0, cin};
                    v = (a[31] != b[31]) && (s[31] != a[31]);
                end else begin
                    s = {1'b0, a} + {1'b0, b} + {32'd0, cin};
                    v = (a[31] == b[31]) && (s[31] != a[31]);
                end
                r = s[31:0];
                c = s[32];
            end
            3'd5: r = a << b[4:0];
            3'd6: r = a >> b[4:0];
            default: r = '0;
        endcase
        return {c, r[31], v, (r == 32'd0), r};
    endfunction

    always_comb begin
        {alu_status, alu_out} = alu_fn(alu_a, alu_b, alu_sel, alu_cin);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_status = '0;
    endtask

    // Register-file and sticky-status compare, every cycle, sweeping dbg_addr.
    initial begin : compare
        int k;
        k = 0;
        forever begin
            @(negedge clk);
            dbg_addr = 3'(k);
            k++;
            #1;
            check("dbg_data", dbg_data, m_regs[dbg_addr]);
            check("status_q", {28'd0, status_q}, {28'd0, m_status});
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // One complete command with stall cycles of response backpressure.
    task automatic do_cmd(input logic [3:0] sel, input logic cin, input logic [2:0] rd,
                          input logic [2:0] rs1, input logic [2:0] rs2, input logic imm_en,
                          input logic [31:0] imm, input int stall, input logic noisy,
                          output logic [31:0] res, output logic [3:0] st);
        logic [31:0] exp_a, exp_b;
        logic [35:0] exp;
        @(negedge clk);
        check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_sel = sel; cmd_cin = cin; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
        cmd_imm_en = imm_en; cmd_imm = imm; cmd_valid = 1'b1;
        exp_a = m_regs[rs1];
        exp_b = imm_en ? imm : m_regs[rs2];
        exp = alu_fn(exp_a, exp_b, sel, cin);
        @(posedge clk); #1;   // E0
        cmd_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        cmd_sel = 4'($urandom); cmd_rd = 3'($urandom); cmd_rs1 = 3'($urandom);
        cmd_rs2 = 3'($urandom); cmd_imm = $urandom; cmd_imm_en = 1'($urandom);
        rsp_ready = 1'($urandom_range(0, 1));
        check("alu_a", alu_a, exp_a);
        check("alu_b", alu_b, exp_b);
        check("alu_sel", {28'd0, alu_sel}, {28'd0, sel});
        check("alu_cin", {31'd0, alu_cin}, {31'd0, cin});
        check("cmd_ready_exec", {31'd0, cmd_ready}, 32'd0);
        check("rsp_valid_exec", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;   // E1
        m_regs[rd] = exp[31:0];
        m_status = exp[35:32];
        rsp_ready = (stall == 0);
        check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("rsp_data", rsp_data, exp[31:0]);
        check("rsp_status", {28'd0, rsp_status}, {28'd0, exp[35:32]});
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_rsp_data", rsp_data, exp[31:0]);
            check("bp_rsp_status", {28'd0, rsp_status}, {28'd0, exp[35:32]});
            check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;   // E2
        cmd_valid = 1'b0;
        rsp_ready = 1'($urandom_range(0, 1));
        check("done_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("done_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("alu_a_hold", alu_a, exp_a);
        check("alu_b_hold", alu_b, exp_b);
        res = exp[31:0];
        st = exp[35:32];
    endtask

    initial begin : stim
        logic [31:0] r;
        logic [3:0]  s;
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (9) @(negedge clk);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);

        // Immediate XOR into reg2.
        do_cmd(SEL_XOR, 1'b0, 3'd2, 3'd1, 3'd0, 1'b1, 32'hA5A5_0000, 0, 1'b0, r, s);
        check("xor_lit", r, 32'hA5A5_0000);
        check("xor_reg2_model", m_regs[2], 32'hA5A5_0000);

        // Add with carry-out: reg2 = all ones, + 1.
        do_cmd(SEL_XOR, 1'b0, 3'd2, 3'd0, 3'd0, 1'b1, 32'hFFFF_FFFF, 0, 1'b0, r, s);
        do_cmd(SEL_ADD, 1'b0, 3'd1, 3'd2, 3'd0, 1'b1, 32'd1, 0, 1'b0, r, s);
        check("add_lit", r, 32'd0);
        check("add_carry_lit", {31'd0, s[STATUS_C]}, 32'd1);

        // Subtract 10 - 3 (cin=1 means no borrow).
        do_cmd(SEL_XOR, 1'b0, 3'd3, 3'd0, 3'd0, 1'b1, 32'd10, 0, 1'b0, r, s);
        do_cmd(SEL_XOR, 1'b0, 3'd4, 3'd0, 3'd0, 1'b1, 32'd3, 0, 1'b0, r, s);
        do_cmd(SEL_SUB, 1'b1, 3'd5, 3'd3, 3'd4, 1'b0, 32'd0, 0, 1'b0, r, s);
        check("sub_lit", r, 32'd7);

        // Dependency: rd == rs1 uses the old value, next command the new one.
        do_cmd(SEL_ADD, 1'b0, 3'd3, 3'd3, 3'd0, 1'b1, 32'd5, 0, 1'b0, r, s);
        check("dep_first_lit", r, 32'd15);
        do_cmd(SEL_ADD, 1'b0, 3'd6, 3'd3, 3'd0, 1'b1, 32'd1, 0, 1'b0, r, s);
        check("dep_second_lit", r, 32'd16);

        // Backpressure for 5 cycles.
        do_cmd(SEL_OR, 1'b0, 3'd7, 3'd3, 3'd5, 1'b0, 32'd0, 5, 1'b0, r, s);
        check("bp_lit", r, 32'd15);

        // SEL_ZERO clears rd and sets Z.
        do_cmd(SEL_ZERO, 1'b1, 3'd3, 3'd2, 3'd4, 1'b0, 32'd0, 1, 1'b0, r, s);
        check("zero_lit", r, 32'd0);
        check("zero_z_lit", {31'd0, s[STATUS_Z]}, 32'd1);
        check("zero_reg3_model", m_regs[3], 32'd0);

        // Reset during EXEC: no response, everything back to reset state.
        @(negedge clk);
        cmd_sel = SEL_XOR; cmd_rd = 3'd7; cmd_rs1 = 3'd6; cmd_imm_en = 1'b1;
        cmd_imm = 32'h1234_5678; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        end

        // Randomized commands.
        for (int n = 0; n < 200; n++) begin
            logic [31:0] imm;
            case ($urandom_range(0, 3))
                0: imm = 32'($urandom_range(0, 40));
                1: imm = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                2: imm = 32'h8000_0000 ^ 32'($urandom_range(0, 3));
                default: imm = $urandom;
            endcase
            do_cmd(4'($urandom), 1'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                   1'($urandom_range(0, 2) != 0), imm, $urandom_range(0, 3), 1'b1, r, s);
        end

        repeat (9) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command-driven controller on the initiator side of the ALU operand/result interface. It accepts one operation at a time over a valid/ready command channel and reads operands from an internal 8x32 register file. It drives the ALU's A, B, C_in and Select inputs from registers, captures ALU_out and Status one cycle later, writes the result back, and returns it on a valid/ready response channel. It sits between the instruction front end and the combinational ALU, which the parent instantiates.

## Interface
- NREGS, 8, register-file depth; address width is log2(NREGS) = 3
- WIDTH, 32, datapath width
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_sel  in  4  ALU Select code: [2:0] chooses the result, [3] selects add/subtract
- cmd_cin  in  1  carry-in driven to the ALU
- cmd_rd, cmd_rs1, cmd_rs2  in  3 each  destination and source register indices
- cmd_imm_en  in  1  use cmd_imm instead of rs2 for the B operand
- cmd_imm  in  32  immediate operand
- alu_a, alu_b  out  32  ALU operands
- alu_sel  out  4  ALU Select
- alu_cin  out  1  ALU C_in
- alu_out  in  32  ALU result, combinational from alu_* outputs
- alu_status  in  4  ALU Status as {C, N, V, Z}
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_data  out  32  captured result
- rsp_status  out  4  captured status
- status_q  out  4  status of the last completed operation (sticky)
- dbg_addr  in  3  debug read address
- dbg_data  out  32  combinational register-file read

## Operation
FSM states: IDLE, EXEC, RESP.
- IDLE
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready:
    - alu_a <= reg[rs1]
    - alu_b <= cmd_imm_en ? cmd_imm : reg[rs2]
    - alu_sel <= cmd_sel, alu_cin <= cmd_cin
    - latch rd
    - go to EXEC
- EXEC
  - cmd_ready=0; the ALU settles combinationally.
  - At the next edge:
    - reg[rd] <= alu_out
    - rsp_data <= alu_out
    - rsp_status <= alu_status
    - status_q <= alu_status
    - go to RESP
- RESP
  - rsp_valid=1, holding rsp_data and rsp_status stable.
  - On rsp_valid&&rsp_ready, go to IDLE.
- Result selection by Select[2:0]:
  - 0 XOR, 1 AND, 2 OR, 3 NOR
  - 4 add (Select[3]=0) or subtract (Select[3]=1)
  - 5 and 6 shift results
  - 7 zero
- All 16 codes are legal; the sequencer never decodes cmd_sel.
- Operands are read at the accept edge, before writeback. rd==rs1 or rd==rs2 therefore uses the old value.
- A following command observes the written value.
- Every register, including reg[0], is writable.
- Select code 7 writes 0 into rd.

## Timing
- Reset values while rst_n=0:
  - state=IDLE, cmd_ready=1, rsp_valid=0
  - alu_a=alu_b=0, alu_sel=0, alu_cin=0
  - rsp_data=0, rsp_status=0, status_q=0
  - all registers=0
  - dbg_data reflects reg[dbg_addr]
- Let E0 be the accept edge.
  - alu_* are valid from E0 to E1.
  - Result is captured at E1; rsp_valid=1 from E1.
  - With rsp_ready held high, the response completes at E2 and cmd_ready=1 after E2.
  - The next accept can happen at E3, so the minimum command interval is 3 cycles.
- cmd_ready is 0 in EXEC and RESP. A cmd_valid asserted then is ignored until IDLE, and the command must stay stable.
- Backpressure: rsp_ready=0 holds RESP indefinitely. Outputs stay stable and no new command is accepted.
- alu_* outputs hold their values until the next accept, not just through EXEC.
- Reset asserted mid-operation:
  - immediate return to the reset state
  - no writeback if reset hits before E1
  - a pending response is discarded
- dbg_data is updated by the writeback in the same edge as status_q.

## Structure
- Package alu_seq_pkg holds:
  - the state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2)
  - Select constants SEL_XOR=4'd0, SEL_AND=4'd1, SEL_OR=4'd2, SEL_NOR=4'd3, SEL_ADD=4'd4, SEL_SUB=4'd12, SEL_SHA=4'd5, SEL_SHB=4'd6, SEL_ZERO=4'd7
  - the status bit indices C=3, N=2, V=1, Z=0
- Sub-module alu_seq_regfile:
  - NREGS x WIDTH
  - two combinational read ports plus the debug read port
  - one synchronous write port
  - async active-low clear
- The top level contains the FSM, the operand/control registers and the response registers.

## Test plan
- Reset: pulse rst_n low for 2 cycles -> cmd_ready=1, rsp_valid=0, every reg reads 0 via dbg, status_q=0.
- Immediate XOR: reg1=0 with SEL_XOR, imm 0xA5A5_0000, rd=2 -> rsp_data=0xA5A5_0000 at E1; dbg reg2=0xA5A5_0000.
- Add with carry: reg2=0xFFFF_FFFF, imm 1, cin=0, SEL_ADD -> rsp_data=0, rsp_status[3]=1.
- Subtract: reg3=10, reg4=3, SEL_SUB -> rsp_data=7.
- Dependency: rd=rs1=3, then rs1=3 on the next command -> the first command uses the old value and the second sees the new one.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_data stable, cmd_ready=0. rsp_ready=1 -> IDLE next cycle.
- Reset at EXEC -> rd unchanged, rsp_valid never asserts.
- SEL_ZERO -> rd=0 and rsp_status[0]=1.
